// File: rtl/dmem_responder_pkg.sv
// Shared widths, latency default and state encoding for the data-memory responder.
package dmem_responder_pkg;

    localparam int unsigned DMEM_DATA_W  = 16;
    localparam int unsigned DMEM_ADDR_W  = 10;
    localparam int unsigned DMEM_DEPTH   = 1024;
    localparam int unsigned DMEM_LATENCY = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned min1_clog2(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with a registered read port that only updates on re_i.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DATA_W = DMEM_DATA_W,
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DEPTH  = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wd_i,
    output logic [DATA_W-1:0] rd_o
);

    localparam int unsigned IDX_W = min1_clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic [IDX_W-1:0]  idx;

    // Caller masks we_i/re_i for addresses beyond DEPTH.
    assign idx = IDX_W'(addr_i);

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx] <= wd_i;
        end
        if (re_i) begin
            rd_q <= mem_q[idx];
        end
    end

    assign rd_o = rd_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: captures one request at a time, holds the pipeline
// with a registered stall for LATENCY cycles, then performs the array access.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DATA_W  = DMEM_DATA_W,
    parameter int unsigned ADDR_W  = DMEM_ADDR_W,
    parameter int unsigned DEPTH   = DMEM_DEPTH,
    parameter int unsigned LATENCY = DMEM_LATENCY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              stall,
    output logic              err,
    input  logic              err_clr
);

    localparam int unsigned CNT_W = min1_clog2(LATENCY);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              op_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              stall_q;
    logic              valid_q;
    logic              err_q;
    logic              zero_q;

    logic              req_c;
    logic              capture_c;
    logic              done_c;
    logic              acc_wr_c;
    logic [ADDR_W-1:0] acc_addr_c;
    logic [DATA_W-1:0] acc_wd_c;
    logic              acc_oor_c;
    logic              in_oor_c;
    logic              err_set_c;
    logic [DATA_W-1:0] ram_rd;

    assign req_c     = read | write;
    assign capture_c = (state_q == ST_IDLE) && req_c;
    assign in_oor_c  = 32'(addr) >= DEPTH;

    // With zero latency the access is taken straight from the request inputs.
    always_comb begin
        acc_wr_c   = op_wr_q;
        acc_addr_c = addr_q;
        acc_wd_c   = wdata_q;
        done_c     = (state_q == ST_BUSY) && (cnt_q == '0);
        if (LATENCY == 0) begin
            acc_wr_c   = write;
            acc_addr_c = addr;
            acc_wd_c   = wdata;
            done_c     = capture_c;
        end
    end

    assign acc_oor_c = 32'(acc_addr_c) >= DEPTH;
    assign err_set_c = (capture_c && read && write)
                     || (capture_c && in_oor_c)
                     || ((state_q == ST_BUSY) && req_c);

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk    (clk),
        .we_i   (done_c && acc_wr_c && !acc_oor_c),
        .re_i   (done_c && !acc_wr_c && !acc_oor_c),
        .addr_i (acc_addr_c),
        .wd_i   (acc_wd_c),
        .rd_o   (ram_rd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            stall_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            valid_q <= done_c && !acc_wr_c;
            if (done_c && !acc_wr_c) begin
                zero_q <= acc_oor_c;
            end
            if (err_set_c) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (capture_c) begin
                        op_wr_q <= write;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (LATENCY != 0) begin
                            state_q <= ST_BUSY;
                            cnt_q   <= CNT_W'(LATENCY - 1);
                            stall_q <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        stall_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    // zero_q covers reset and out-of-range reads without clearing the RAM register.
    assign rdata       = zero_q ? '0 : ram_rd;
    assign rdata_valid = valid_q;
    assign stall       = stall_q;
    assign err         = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 2, 0, 1) against a
// word-array reference model, directed cases followed by random traffic.
module tb_dmem_responder;

    localparam int unsigned NDUT  = 3;
    localparam int unsigned DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_s    [NDUT];
    logic        wr_s    [NDUT];
    logic        clr_s   [NDUT];
    logic [10:0] addr_s  [NDUT];
    logic [15:0] wd_s    [NDUT];
    logic [15:0] rdata_s [NDUT];
    logic        valid_s [NDUT];
    logic        stall_s [NDUT];
    logic        err_s   [NDUT];

    logic [15:0] mdl_mem [NDUT][DEPTH];
    logic        mdl_err [NDUT];
    logic [15:0] mdl_rd  [NDUT];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_responder #(
            .DATA_W  (16),
            .ADDR_W  (11),
            .DEPTH   (DEPTH),
            .LATENCY ((g == 0) ? 2 : ((g == 1) ? 0 : 1))
        ) u_dut (
            .clk         (clk),
            .reset       (rst),
            .read        (rd_s[g]),
            .write       (wr_s[g]),
            .addr        (addr_s[g]),
            .wdata       (wd_s[g]),
            .rdata       (rdata_s[g]),
            .rdata_valid (valid_s[g]),
            .stall       (stall_s[g]),
            .err         (err_s[g]),
            .err_clr     (clr_s[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 1);
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s[dut%0d]: got %0h expected %0h", tag, k, got, exp);
        end
    endtask

    // Issue one request at the current negedge and follow it to completion.
    task automatic access(input int k, input bit rd, input bit wr, input int a,
                          input logic [15:0] wd);
        bit oor;
        bit is_rd;
        oor   = (a >= int'(DEPTH));
        is_rd = rd && !wr;
        rd_s[k] = rd; wr_s[k] = wr; addr_s[k] = 11'(a); wd_s[k] = wd;
        if ((rd && wr) || (oor && (rd || wr))) mdl_err[k] = 1'b1;
        if (wr && !oor) mdl_mem[k][a] = wd;
        if (is_rd) mdl_rd[k] = oor ? 16'h0 : mdl_mem[k][a];
        @(negedge clk);
        rd_s[k] = 1'b0; wr_s[k] = 1'b0;
        for (int i = 0; i < lat_of(k); i++) begin
            chk("stall_hi", k, 32'(stall_s[k]), 32'd1);
            chk("valid_lo", k, 32'(valid_s[k]), 32'd0);
            @(negedge clk);
        end
        chk("stall_lo", k, 32'(stall_s[k]), 32'd0);
        chk("valid", k, 32'(valid_s[k]), 32'(is_rd));
        chk("rdata", k, 32'(rdata_s[k]), 32'(mdl_rd[k]));
        chk("err", k, 32'(err_s[k]), 32'(mdl_err[k]));
    endtask

    task automatic clear_err(input int k);
        clr_s[k] = 1'b1;
        @(negedge clk);
        clr_s[k] = 1'b0;
        mdl_err[k] = 1'b0;
        chk("err_clr", k, 32'(err_s[k]), 32'd0);
    endtask

    initial begin
        int k;
        int sel;
        int a;
        logic [15:0] wd;

        for (int i = 0; i < int'(NDUT); i++) begin
            rd_s[i] = 1'b0; wr_s[i] = 1'b0; clr_s[i] = 1'b0;
            addr_s[i] = '0; wd_s[i] = '0;
            mdl_err[i] = 1'b0; mdl_rd[i] = 16'h0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < int'(NDUT); i++) begin
            chk("rst_stall", i, 32'(stall_s[i]), 32'd0);
            chk("rst_rdata", i, 32'(rdata_s[i]), 32'd0);
            chk("rst_valid", i, 32'(valid_s[i]), 32'd0);
            chk("rst_err", i, 32'(err_s[i]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < int'(NDUT); i++)
            for (int j = 0; j < 24; j++) access(i, 1'b0, 1'b1, j, 16'($urandom));
        access(0, 1'b0, 1'b1, 476, 16'h4760);

        access(0, 1'b0, 1'b1, 5, 16'hBEEF);
        access(0, 1'b1, 1'b0, 5, 16'h0);
        chk("beef", 0, 32'(rdata_s[0]), 32'h0000BEEF);

        access(1, 1'b0, 1'b1, 3, 16'h1234);
        access(1, 1'b1, 1'b0, 3, 16'h0);
        chk("l0_1234", 1, 32'(rdata_s[1]), 32'h00001234);

        access(0, 1'b0, 1'b1, 1500, 16'hFFFF);
        access(0, 1'b1, 1'b0, 1500, 16'h0);
        chk("oor_zero", 0, 32'(rdata_s[0]), 32'd0);
        access(0, 1'b1, 1'b0, 476, 16'h0);
        chk("alias_476", 0, 32'(rdata_s[0]), 32'h00004760);
        clear_err(0);

        access(0, 1'b1, 1'b1, 7, 16'h00AA);
        access(0, 1'b1, 1'b0, 7, 16'h0);
        chk("both_wr", 0, 32'(rdata_s[0]), 32'h000000AA);
        clear_err(0);

        // Strobe while busy is flagged and not serviced.
        access(0, 1'b0, 1'b1, 21, 16'h7777);
        wr_s[0] = 1'b1; addr_s[0] = 11'd20; wd_s[0] = 16'h1357;
        @(negedge clk);
        chk("busy_stall", 0, 32'(stall_s[0]), 32'd1);
        addr_s[0] = 11'd21; wd_s[0] = 16'hDEAD;
        @(negedge clk);
        wr_s[0] = 1'b0;
        chk("busy_stall2", 0, 32'(stall_s[0]), 32'd1);
        chk("busy_err", 0, 32'(err_s[0]), 32'd1);
        @(negedge clk);
        chk("busy_done", 0, 32'(stall_s[0]), 32'd0);
        mdl_mem[0][20] = 16'h1357;
        mdl_err[0] = 1'b1;
        access(0, 1'b1, 1'b0, 21, 16'h0);
        access(0, 1'b1, 1'b0, 20, 16'h0);
        clear_err(0);

        // Set beats a simultaneous clear.
        clr_s[1] = 1'b1;
        access(1, 1'b1, 1'b1, 8, 16'h0808);
        clr_s[1] = 1'b0;
        chk("set_wins", 1, 32'(err_s[1]), 32'd1);

        access(2, 1'b1, 1'b0, 0, 16'h0);
        access(2, 1'b1, 1'b0, 1, 16'h0);
        access(2, 1'b1, 1'b0, 2, 16'h0);
        @(negedge clk);
        chk("pulse_one", 2, 32'(valid_s[2]), 32'd0);

        // Reset during the first busy cycle drops the pending write.
        access(0, 1'b0, 1'b1, 9, 16'h0001);
        wr_s[0] = 1'b1; addr_s[0] = 11'd9; wd_s[0] = 16'h5555;
        @(negedge clk);
        wr_s[0] = 1'b0;
        chk("pre_rst_stall", 0, 32'(stall_s[0]), 32'd1);
        #1 rst = 1'b1;
        #1 chk("async_stall", 0, 32'(stall_s[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < int'(NDUT); i++) begin
            mdl_err[i] = 1'b0;
            mdl_rd[i] = 16'h0;
            chk("post_rst_err", i, 32'(err_s[i]), 32'd0);
        end
        access(0, 1'b1, 1'b0, 9, 16'h0);
        chk("rst_kept", 0, 32'(rdata_s[0]), 32'h00000001);

        for (int n = 0; n < 120; n++) begin
            k   = int'($urandom_range(NDUT - 1, 0));
            sel = int'($urandom_range(9, 0));
            a   = ($urandom_range(7, 0) == 0) ? int'($urandom_range(2047, 1024))
                                              : int'($urandom_range(23, 0));
            wd  = 16'($urandom);
            if (sel == 0)      clear_err(k);
            else if (sel < 4)  access(k, 1'b0, 1'b1, a, wd);
            else if (sel == 4) access(k, 1'b1, 1'b1, a, wd);
            else               access(k, 1'b1, 1'b0, a, wd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
